// File: rtl/fft_framer_pkg.sv
// Shared definitions for the FFT stream framer: frame state, error codes and
// the frame-size legality check.
package fft_framer_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_OVF  = 2'b01;

   // Legal sizes are powers of two between min and 2^(pts_w-1) inclusive.
   function automatic logic is_legal_pts(input logic [31:0] pts, input int min, input int pts_w);
      logic [31:0] max_pts;
      max_pts = 32'd1 << (pts_w - 1);
      return (pts != 32'd0) && ((pts & (pts - 32'd1)) == 32'd0) &&
             (pts >= 32'(min)) && (pts <= max_pts);
   endfunction

endpackage

// File: rtl/fft_framer_fifo.sv
// Single-clock show-ahead FIFO: rd_data always shows the head entry, and
// rd_en pops it. Storage is not reset; only pointers and occupancy are.
module fft_framer_fifo #(
   parameter int FIFO_AW = 10,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty
);

   localparam int DEPTH = 1 << FIFO_AW;

   logic [DATA_W-1:0]  mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + FIFO_AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + (FIFO_AW+1)'(1);
            2'b01:   count <= count - (FIFO_AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == (FIFO_AW+1)'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/fft_stream_framer.sv
// Frames an unthrottled sample stream into Avalon-ST packets for a streaming FFT.
// Optional FFT_FRAMER_OVF_CNT_EN adds a saturating dropped-sample counter port.
module fft_stream_framer
   import fft_framer_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int PTS_W   = 15,
   parameter int MIN_PTS = 64,
   parameter int FIFO_AW = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [PTS_W-1:0]  cfg_fftpts,
   input  logic              cfg_inverse,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_real,
   input  logic [DATA_W-1:0] in_imag,
   output logic              source_valid,
   input  logic              source_ready,
   output logic              source_sop,
   output logic              source_eop,
   output logic [DATA_W-1:0] source_real,
   output logic [DATA_W-1:0] source_imag,
   output logic [1:0]        source_error,
   output logic [PTS_W-1:0]  fftpts_out,
   output logic              inverse_out,
   output logic              cfg_err,
   output logic              busy
`ifdef FFT_FRAMER_OVF_CNT_EN
   ,
   output logic [15:0]       ovf_count
`endif
);

   state_t               state, state_nxt;
   logic                 vld_p0;
   logic [2*DATA_W-1:0]  data_p0;
   logic [2*DATA_W-1:0]  head;
   logic                 fifo_full, fifo_empty, fifo_wr;
   logic                 rd, drop, cfg_legal, start, reject, at_eop;
   logic [PTS_W-1:0]     beat_cnt;
   logic                 ovf_frame, ovf_carry;

   assign cfg_legal = is_legal_pts(32'(cfg_fftpts), MIN_PTS, PTS_W);

   // Stage p0: capture input; enable gates what may enter the FIFO
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) vld_p0 <= 1'b0;
      else          vld_p0 <= in_valid && enable;
   end

   always_ff @(posedge clk) begin
      data_p0 <= {in_real, in_imag};
   end

   // Stage p1: FIFO; a pop in the same cycle frees the slot for the write
   assign rd      = source_valid && source_ready;
   assign fifo_wr = vld_p0 && (!fifo_full || rd);
   assign drop    = vld_p0 && fifo_full && !rd;

   fft_framer_fifo #(
      .FIFO_AW (FIFO_AW),
      .DATA_W  (2*DATA_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (fifo_wr),
      .wr_data (data_p0),
      .rd_en   (rd),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      reject    = 1'b0;
      case (state)
         IDLE: begin
            if (enable && cfg_legal) begin
               state_nxt = STREAM;
               start     = 1'b1;
            end else if (enable) begin
               reject = 1'b1;
            end
         end
         STREAM: begin
            if (rd && source_eop) begin
               if (enable && cfg_legal) start = 1'b1;
               else                     state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      source_valid = 1'b0;
      source_sop   = 1'b0;
      source_eop   = 1'b0;
      source_error = ERR_NONE;
      busy         = 1'b0;
      at_eop       = 1'b0;
      if (state == STREAM) begin
         busy         = 1'b1;
         at_eop       = (beat_cnt == fftpts_out - PTS_W'(1));
         source_valid = !fifo_empty;
         source_sop   = source_valid && (beat_cnt == '0);
         source_eop   = source_valid && at_eop;
         if (source_eop && ovf_frame) source_error = ERR_OVF;
      end
   end

   assign source_real = source_valid ? head[2*DATA_W-1 -: DATA_W] : '0;
   assign source_imag = source_valid ? head[DATA_W-1:0]           : '0;

   // While the eop beat is on the bus its error code must hold, so drops in
   // that window are carried into the following frame instead.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fftpts_out  <= '0;
         inverse_out <= 1'b0;
         beat_cnt    <= '0;
         ovf_frame   <= 1'b0;
         ovf_carry   <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         cfg_err   <= reject;
         ovf_carry <= source_eop && !rd && (ovf_carry || drop);
         if (start) begin
            fftpts_out  <= cfg_fftpts;
            inverse_out <= cfg_inverse;
            beat_cnt    <= '0;
            ovf_frame   <= (state == STREAM) && (ovf_carry || drop);
         end else begin
            if (rd)                  beat_cnt  <= beat_cnt + PTS_W'(1);
            if (drop && !source_eop) ovf_frame <= 1'b1;
         end
      end
   end

`ifdef FFT_FRAMER_OVF_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                         ovf_count <= '0;
      else if (drop && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fft_stream_framer.sv
// Randomized bench for fft_stream_framer against a queue-based frame model.
// Build with FFT_FRAMER_OVF_CNT_EN to also check the dropped-sample counter.
module tb_fft_stream_framer;

   localparam int DATA_W  = 16;
   localparam int PTS_W   = 15;
   localparam int MIN_PTS = 64;
   localparam int FIFO_AW = 4;
   localparam int DEPTH   = 1 << FIFO_AW;

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic              enable = 1'b0;
   logic [PTS_W-1:0]  cfg_fftpts = '0;
   logic              cfg_inverse = 1'b0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_real = '0;
   logic [DATA_W-1:0] in_imag = '0;
   logic              source_ready = 1'b0;
   logic              source_valid, source_sop, source_eop, inverse_out, cfg_err, busy;
   logic [DATA_W-1:0] source_real, source_imag;
   logic [1:0]        source_error;
   logic [PTS_W-1:0]  fftpts_out;
`ifdef FFT_FRAMER_OVF_CNT_EN
   logic [15:0]       ovf_count;
`endif

   fft_stream_framer #(
      .DATA_W (DATA_W), .PTS_W (PTS_W), .MIN_PTS (MIN_PTS), .FIFO_AW (FIFO_AW)
   ) dut (
      .clk (clk), .reset_n (reset_n), .enable (enable),
      .cfg_fftpts (cfg_fftpts), .cfg_inverse (cfg_inverse),
      .in_valid (in_valid), .in_real (in_real), .in_imag (in_imag),
      .source_valid (source_valid), .source_ready (source_ready),
      .source_sop (source_sop), .source_eop (source_eop),
      .source_real (source_real), .source_imag (source_imag),
      .source_error (source_error), .fftpts_out (fftpts_out),
      .inverse_out (inverse_out), .cfg_err (cfg_err), .busy (busy)
`ifdef FFT_FRAMER_OVF_CNT_EN
      , .ovf_count (ovf_count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: accepted samples sit in a queue, one capture stage ahead of it.
   logic [31:0] m_q[$];
   bit          m_pend;
   logic [31:0] m_pend_d;
   bit          m_frame, m_inv, m_ovf, m_carry, m_cfgerr;
   int          m_pts, m_cnt;

   function automatic bit legal(input int p);
      return (p >= MIN_PTS) && (p <= (1 << (PTS_W - 1))) && ($countones(p) == 1);
   endfunction

   function automatic bit m_valid();
      return m_frame && (m_q.size() > 0);
   endfunction

   function automatic bit m_eop();
      return m_valid() && (m_cnt == m_pts - 1);
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_pend = 0; m_pend_d = '0;
      m_frame = 0; m_inv = 0; m_ovf = 0; m_carry = 0; m_cfgerr = 0;
      m_pts = 0; m_cnt = 0;
   endtask

   task automatic model_step();
      bit v, eop, rd, wr, drop, leg, start;
      if (!reset_n) begin
         model_reset();
         return;
      end
      v     = m_valid();
      eop   = m_eop();
      rd    = v && source_ready;
      wr    = m_pend && ((m_q.size() < DEPTH) || rd);
      drop  = m_pend && !wr;
      leg   = legal(int'(cfg_fftpts));
      start = enable && leg && (!m_frame || (rd && eop));
      m_cfgerr = !m_frame && enable && !leg;
      if (drop) begin
         if (eop) m_carry = 1;
         else     m_ovf = 1;
      end
      if (rd) void'(m_q.pop_front());
      if (start) begin
         m_ovf   = m_frame ? m_carry : 1'b0;
         m_frame = 1; m_pts = int'(cfg_fftpts); m_inv = cfg_inverse; m_cnt = 0;
         m_carry = 0;
      end else if (rd && eop) begin
         m_frame = 0; m_carry = 0;
      end else if (rd) begin
         m_cnt++;
      end
      if (wr) m_q.push_back(m_pend_d);
      m_pend   = in_valid && enable;
      m_pend_d = {in_real, in_imag};
   endtask

   bit          prev_hold, first_seen, first_sop;
   logic [36:0] prev_vec;
   int          beats, eop_seen, cfgerr_seen, valid_seen;
   logic [1:0]  eop_errs[$];

   task automatic compare_outputs();
      bit          v, sop, eop;
      logic [1:0]  err;
      logic [31:0] d;
      logic [36:0] now_vec;
      v   = m_valid();
      eop = m_eop();
      sop = v && (m_cnt == 0);
      err = (eop && m_ovf) ? 2'b01 : 2'b00;
      d   = v ? m_q[0] : 32'd0;
      check("ctl", 64'({source_valid, source_sop, source_eop, source_error, busy, cfg_err, inverse_out}),
                   64'({v, sop, eop, err, m_frame, m_cfgerr, m_inv}));
      check("data", 64'({source_real, source_imag}), 64'(d));
      check("pts", 64'(fftpts_out), 64'(m_pts));
      now_vec = {source_valid, source_sop, source_eop, source_error, source_real, source_imag};
      if (prev_hold) check("hold", 64'(now_vec), 64'(prev_vec));
      prev_hold = source_valid && !source_ready;
      prev_vec  = now_vec;
      if (cfg_err) cfgerr_seen++;
      if (source_valid) valid_seen++;
      if (source_valid && source_ready) begin
         if (!first_seen) begin
            first_seen = 1;
            first_sop  = source_sop;
         end
         beats = source_sop ? 1 : beats + 1;
         if (source_eop) begin
            eop_seen++;
            eop_errs.push_back(source_error);
            check("frame_len", 64'(beats), 64'(m_pts));
         end
      end
   endtask

   task automatic cycle();
      in_real = 16'($urandom);
      in_imag = 16'($urandom);
      @(negedge clk);
      compare_outputs();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      #1;
      check("rst_ctl", 64'({source_valid, source_sop, source_eop, source_error, busy, cfg_err, inverse_out}), 64'd0);
      check("rst_data", 64'({source_real, source_imag}), 64'd0);
      check("rst_pts", 64'(fftpts_out), 64'd0);
      model_reset();
      prev_hold = 0; first_seen = 0; first_sop = 0;
      beats = 0; eop_seen = 0; cfgerr_seen = 0; valid_seen = 0;
      eop_errs.delete();
      repeat (2) cycle();
      reset_n = 1'b1;
   endtask

   task automatic wait_beat(input int n, input string tag);
      bit hit;
      hit = 0;
      for (int i = 0; i < 400 && !hit; i++) begin
         if (m_frame && m_cnt == n) hit = 1;
         else cycle();
      end
      check(tag, 64'(hit), 64'd1);
   endtask

   task automatic wait_idle(input string tag);
      bit hit;
      hit = 0;
      for (int i = 0; i < 400 && !hit; i++) begin
         if (!m_frame) hit = 1;
         else cycle();
      end
      check(tag, 64'(hit), 64'd1);
   endtask

   initial begin
      #2;
      apply_reset();

      // Continuous 64-point frames, ready held high
      enable = 1; cfg_fftpts = 15'd64; in_valid = 1; source_ready = 1;
      for (int i = 0; i < 200; i++) begin
         cfg_inverse = 1'($urandom);
         cycle();
      end
      check("a_frames", 64'(eop_seen), 64'd3);

      // Random ready and input gaps
      apply_reset();
      enable = 1; cfg_fftpts = 15'd64;
      for (int i = 0; i < 400; i++) begin
         source_ready = 1'($urandom_range(0, 1));
         in_valid     = ($urandom_range(0, 3) != 0);
         cfg_inverse  = 1'($urandom);
         cycle();
      end
      check("b_frames_seen", 64'(eop_seen > 0), 64'd1);

      // Illegal sizes rejected, then 128 accepted
      apply_reset();
      enable = 1; in_valid = 0; source_ready = 1; cfg_fftpts = 15'd100;
      repeat (4) cycle();
      cfg_fftpts = 15'd48;
      repeat (4) cycle();
      cfg_fftpts = 15'd128; in_valid = 1;
      cycle();
      check("c_cfgerr", 64'(cfgerr_seen), 64'd8);
      check("c_no_valid", 64'(valid_seen), 64'd0);
      repeat (150) cycle();
      check("c_pts128", 64'(fftpts_out), 64'd128);
      check("c_frames", 64'(eop_seen), 64'd1);

      // Overflow: 40 samples into a 16-deep FIFO with ready low
      apply_reset();
      enable = 1; cfg_fftpts = 15'd64; source_ready = 0; in_valid = 1;
      repeat (40) cycle();
      in_valid = 0;
      repeat (2) cycle();
`ifdef FFT_FRAMER_OVF_CNT_EN
      check("d_ovf_count", 64'(ovf_count), 64'd24);
`endif
      source_ready = 1; in_valid = 1;
      repeat (150) cycle();
      check("d_frames", 64'(eop_errs.size()), 64'd2);
      if (eop_errs.size() >= 2) begin
         check("d_err_ovf", 64'(eop_errs[0]), 64'd1);
         check("d_err_clean", 64'(eop_errs[1]), 64'd0);
      end

      // Enable dropped at beat 10: frame still completes
      apply_reset();
      enable = 1; cfg_fftpts = 15'd64; in_valid = 1; source_ready = 1;
      wait_beat(10, "e_beat10");
      enable = 0;
      repeat (30) cycle();
      check("e_busy_mid", 64'(busy), 64'd1);
      enable = 1; cfg_fftpts = 15'd0;
      wait_idle("e_idle");
      enable = 0;
      cycle();
      check("e_busy_end", 64'(busy), 64'd0);
      check("e_frames", 64'(eop_seen), 64'd1);

      // Reset at beat 30, then a fresh frame
      apply_reset();
      enable = 1; cfg_fftpts = 15'd64; in_valid = 1; source_ready = 1;
      wait_beat(30, "f_beat30");
      apply_reset();
      repeat (80) cycle();
      check("f_sop", 64'(first_sop), 64'd1);
      check("f_frames", 64'(eop_seen), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
